// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle operations plus an iterative
// shift-add multiplier / restoring divider that owns the HI/LO registers.
module alu_muldiv #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR   = 4'b0011,
    OP_SLL  = 4'b0100, OP_SRL  = 4'b0101, OP_SUB  = 4'b0110, OP_SLT   = 4'b0111,
    OP_SRA  = 4'b1000, OP_SLTU = 4'b1001, OP_MFHI = 4'b1010, OP_MFLO  = 4'b1011,
    OP_MULT = 4'b1100, OP_MULTU = 4'b1101, OP_DIV = 4'b1110, OP_DIVU  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e state, state_nx;
  op_e    op_q;

  logic             accept;
  logic             is_muldiv;
  logic             last_iter;
  logic [SHW-1:0]   cnt;

  // Engine registers
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div_r;
  logic               dz_r;
  logic               neg_q;
  logic               neg_r;

  // Combinational datapath
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ov;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign op_q      = op_e'(op);
  assign is_muldiv = op[3] & op[2];
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == SHW'(WIDTH - 1));

  // ---------------------------------------------------------------- FSM
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (accept && is_muldiv) state_nx = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (last_iter)           state_nx = S_FIX;
      S_FIX:                                 state_nx = S_IDLE;
      default:                               state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // ------------------------------------------------------ single-cycle ALU
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_y  = '0;
    alu_ov = 1'b0;
    case (op_q)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_ADD: begin
        alu_y  = sum;
        alu_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y  = diff;
        alu_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_y = a << shamt;
      OP_SRL:  alu_y = a >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  // ------------------------------------------------------ mul/div engine
  // op[0] selects the unsigned variant; signed ops iterate on magnitudes.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh - {1'b0, opnd};

  // NOTE: engine registers carry no reset; the FSM alone decides when they
  // are meaningful, and every op reloads them on its accepting edge.
  always_ff @(posedge clk) begin
    if (accept && is_muldiv) begin
      cnt      <= '0;
      is_div_r <= op[1];
      dz_r     <= (b == '0);
      a_raw    <= a;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      opnd     <= op[1] ? b_mag : a_mag;
      acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
    end else if (state == S_MUL) begin
      acc <= {mul_sum, acc[WIDTH-1:1]};
      cnt <= cnt + SHW'(1);
    end else if (state == S_DIV) begin
      if (!rem_sub[WIDTH]) acc <= {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                 acc <= {rem_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
      cnt <= cnt + SHW'(1);
    end
  end

  // Sign fix-up: quotient/product negated when operand signs differ,
  // remainder follows the dividend; divide-by-zero overrides both halves.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (!is_div_r) begin
      {fix_hi, fix_lo} = neg_q ? -acc : acc;
    end else if (dz_r) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
      fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      y         <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_muldiv) begin
        y         <= alu_y;
        zero      <= (alu_y == '0);
        overflow  <= alu_ov;
        out_valid <= 1'b1;
      end else if (state == S_FIX) begin
        hi        <= fix_hi;
        lo        <= fix_lo;
        y         <= fix_lo;
        zero      <= (fix_lo == '0);
        overflow  <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: cycle-level arithmetic model on the
// 32-bit instance plus directed literal checks, and an 8-bit MULT latency run.
module tb_alu_muldiv;

  localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_XOR   = 4'd3,
                         OP_SLL  = 4'd4,  OP_SRL  = 4'd5,  OP_SUB  = 4'd6,  OP_SLT   = 4'd7,
                         OP_SRA  = 4'd8,  OP_SLTU = 4'd9,  OP_MFHI = 4'd10, OP_MFLO  = 4'd11,
                         OP_MULT = 4'd12, OP_MULTU = 4'd13, OP_DIV = 4'd14, OP_DIVU  = 4'd15;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, zero, overflow;
  logic [3:0]  op;
  logic [31:0] a, b, y, hi, lo;
  logic [4:0]  shamt;

  logic        in_valid8, in_ready8, out_valid8, zero8, overflow8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, y8, hi8, lo8;
  logic [2:0]  shamt8;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .y(y), .zero(zero),
    .overflow(overflow), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .shamt(shamt8), .out_valid(out_valid8), .y(y8), .zero(zero8),
    .overflow(overflow8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  function automatic void model_alu(input logic [3:0] o, input logic [31:0] x, z,
                                    input logic [4:0] sh, input logic [31:0] h, l,
                                    output logic [31:0] r, output logic v);
    longint sx, sz, s, lim;
    sx  = longint'($signed(x));
    sz  = longint'($signed(z));
    lim = 64'sh7FFF_FFFF;
    s   = 0;
    r   = '0;
    v   = 1'b0;
    case (o)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_ADD:  begin s = sx + sz; r = 32'(s); v = (s > lim) || (s < -lim - 1); end
      OP_SUB:  begin s = sx - sz; r = 32'(s); v = (s > lim) || (s < -lim - 1); end
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = 32'(sx >>> sh);
      OP_SLT:  r = (sx < sz) ? 32'd1 : 32'd0;
      OP_SLTU: r = (x < z) ? 32'd1 : 32'd0;
      OP_MFHI: r = h;
      OP_MFLO: r = l;
      default: r = '0;
    endcase
  endfunction

  function automatic void model_muldiv(input logic [3:0] o, input logic [31:0] x, z,
                                       output logic [31:0] h, l);
    longint      sx, sz;
    logic [63:0] p;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    case (o)
      OP_MULT:  p = 64'(sx * sz);
      OP_MULTU: p = {32'd0, x} * {32'd0, z};
      OP_DIV:   p = (z == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sz), 32'(sx / sz)};
      default:  p = (z == 0) ? {x, 32'hFFFF_FFFF} : {x % z, x / z};
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  int          cyc = 0;
  int          busy = 0;
  logic        exp_ready = 1'b1, exp_out_valid = 1'b0, exp_zero = 1'b1, exp_ov = 1'b0;
  logic [31:0] exp_y = '0, exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        v;
    cyc++;
    exp_out_valid = 1'b0;
    if (reset) begin
      busy = 0; exp_y = '0; exp_zero = 1'b1; exp_ov = 1'b0; exp_hi = '0; exp_lo = '0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        exp_out_valid = 1'b1;
        exp_hi = pend_hi; exp_lo = pend_lo; exp_y = pend_lo;
        exp_zero = (pend_lo == 0); exp_ov = 1'b0;
      end
    end else if (in_valid) begin
      if (op[3:2] == 2'b11) begin
        model_muldiv(op, a, b, pend_hi, pend_lo);
        busy = 33;
      end else begin
        model_alu(op, a, b, shamt, exp_hi, exp_lo, r, v);
        exp_y = r; exp_zero = (r == 0); exp_ov = v; exp_out_valid = 1'b1;
      end
    end
    exp_ready = (busy == 0);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_out_valid));
      if (exp_out_valid) begin
        check("y", 64'(y), 64'(exp_y));
        check("zero", 64'(zero), 64'(exp_zero));
        check("overflow", 64'(overflow), 64'(exp_ov));
      end
      check("hi", 64'(hi), 64'(exp_hi));
      check("lo", 64'(lo), 64'(exp_lo));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic send(input logic [3:0] o, input logic [31:0] x, z, input logic [4:0] sh);
    @(negedge clk);
    op = o; a = x; b = z; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] x, z, input logic [4:0] sh);
    int n;
    send(o, x, z, sh);
    wait_out(40, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, lo_cnt, pulses;
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; shamt8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_y", 64'(y), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    run(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    check("add_lat", 64'(n), 64'd0);
    check("add_y", 64'(y), 64'h8000_0000);
    check("add_ov", 64'(overflow), 64'd1);
    check("add_zero", 64'(zero), 64'd0);
    run(OP_SRA, 32'h8000_0000, 32'h0, 5'd4);
    check("sra_y", 64'(y), 64'hF800_0000);
    run(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("slt_y", 64'(y), 64'd1);
    run(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("sltu_y", 64'(y), 64'd0);
    check("sltu_zero", 64'(zero), 64'd1);

    // MULT with an ADD pulsed mid-operation that must be ignored
    send(OP_MULT, 32'hFFFF_FFFD, 32'h5, 5'd0);
    lat = -1; lo_cnt = 0; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (!in_ready) lo_cnt++;
      if (out_valid) begin pulses++; if (lat < 0) lat = i; end
      if (i == 5) begin op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_busy", 64'(lo_cnt), 64'd33);
    check("mult_pulses", 64'(pulses), 64'd1);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    run(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(OP_DIVU, 32'h1234_5678, 32'h0, 5'd0);
    check("divu0_hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    run(OP_DIV, 32'hFFFF_FFFB, 32'h0, 5'd0);
    check("div0_hilo", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // MULTU then MFHI accepted in the out_valid cycle
    send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_out(40, n);
    op = OP_MFHI; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mfhi_valid", 64'(out_valid), 64'd1);
    check("mfhi_y", 64'(y), 64'hFFFF_FFFE);

    // Model-checked vectors
    run(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_FF00, 5'd0);
    run(OP_OR,   32'hF0F0_F0F0, 32'h0FF0_FF00, 5'd0);
    run(OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_FF00, 5'd0);
    run(OP_SUB,  32'h8000_0000, 32'h0000_0001, 5'd0);
    check("sub_ov_y", {31'd0, overflow, y}, 64'h1_7FFF_FFFF);
    run(OP_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0);
    run(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    run(OP_SLL,  32'h0000_0001, 32'h0, 5'd31);
    run(OP_SRL,  32'h8000_0000, 32'h0, 5'd31);
    run(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0);
    run(OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 5'd0);
    run(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd0);
    run(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 5'd0);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0003, 5'd0);
    run(OP_MULTU, 32'h1234_5678, 32'h0000_0009, 5'd0);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);

    // Reset ten cycles into a DIV
    send(OP_DIV, 32'd100, 32'd7, 5'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_y", 64'(y), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_out", 64'(pulses), 64'd0);

    // WIDTH=8 MULT: latency and busy window of 9 cycles
    check("w8_ready", 64'(in_ready8), 64'd1);
    op8 = OP_MULT; a8 = 8'hFD; b8 = 8'h05; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = -1; lo_cnt = 0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (!in_ready8) lo_cnt++;
      if (out_valid8) begin pulses++; if (lat < 0) lat = i; end
      @(negedge clk);
    end
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_busy", 64'(lo_cnt), 64'd9);
    check("w8_pulses", 64'(pulses), 64'd1);
    check("w8_hilo", {48'd0, hi8, lo8}, 64'hFFF1);
    check("w8_y", 64'(y8), 64'hF1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
